// File: rtl/timer_controller.sv
// timer_controller: keypad entry, load and tick gating for the microwave mm:ss down-counter chain.
// Every output is a register so the counter chain sees clean, glitch-free strobes.
module timer_controller #(
    parameter int TICK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_open,
    input  logic        time_zero,
    output logic        load,
    output logic [15:0] load_digits,
    output logic        cnt_enablen,
    output logic        magnetron_on,
    output logic        done,
    output logic [2:0]  state_dbg
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state, nxt;
    logic [15:0]   entry, entry_nxt, digits_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          door_q, load_nxt, tick, digit;

    assign digit = key_valid && (key_code <= 4'd9);
    assign state_dbg = state;

    // Lower-priority inputs are shadowed: stop_clear > door_open > start > key_valid.
    always_comb begin
        nxt        = state;
        entry_nxt  = entry;
        presc_nxt  = presc;
        load_nxt   = 1'b0;
        digits_nxt = load_digits;
        case (state)
            IDLE: begin
                if (!stop_clear && !door_open && !start && digit) begin
                    entry_nxt = {entry[11:0], key_code};
                    nxt       = ENTRY;
                end
            end
            ENTRY: begin
                if (stop_clear) begin
                    entry_nxt = '0;
                    nxt       = IDLE;
                end else if (door_open) begin
                    nxt = ENTRY;
                end else if (start) begin
                    if (entry != '0) begin
                        load_nxt   = 1'b1;
                        digits_nxt = entry;
                        presc_nxt  = '0;
                        nxt        = COOK;
                    end
                end else if (digit) begin
                    entry_nxt = {entry[11:0], key_code};
                end
            end
            COOK: begin
                if (stop_clear || door_open)
                    nxt = PAUSE;
                else if (time_zero)
                    nxt = DONE;
                else
                    presc_nxt = (presc == LAST) ? '0 : presc + 1'b1;
            end
            PAUSE: begin
                if (stop_clear) begin
                    load_nxt   = 1'b1;
                    digits_nxt = '0;
                    entry_nxt  = '0;
                    nxt        = IDLE;
                end else if (!door_open && start) begin
                    nxt = COOK;
                end
            end
            DONE: begin
                if (key_valid || stop_clear || (door_open && !door_q) || start) begin
                    entry_nxt = '0;
                    nxt       = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
        tick = (state == COOK) && (nxt == COOK) && (presc == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            entry        <= '0;
            presc        <= '0;
            door_q       <= 1'b0;
            load         <= 1'b0;
            load_digits  <= '0;
            cnt_enablen  <= 1'b1;
            magnetron_on <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= nxt;
            entry        <= entry_nxt;
            presc        <= presc_nxt;
            door_q       <= door_open;
            load         <= load_nxt;
            load_digits  <= digits_nxt;
            cnt_enablen  <= !tick;
            magnetron_on <= (nxt == COOK);
            done         <= (nxt == DONE);
        end
    end
endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: directed checks of entry, load, tick spacing, pause/resume, done and reset.
module tb_timer_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        start = 1'b0;
    logic        stop_clear = 1'b0;
    logic        door_open = 1'b0;
    logic        time_zero = 1'b0;
    logic        load;
    logic [15:0] load_digits;
    logic        cnt_enablen;
    logic        magnetron_on;
    logic        done;
    logic [2:0]  state_dbg;
    int          checks = 0;
    int          errors = 0;

    timer_controller #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .start(start), .stop_clear(stop_clear), .door_open(door_open),
        .time_zero(time_zero), .load(load), .load_digits(load_digits),
        .cnt_enablen(cnt_enablen), .magnetron_on(magnetron_on), .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        cyc();
        key_valid = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_load", load, 0);
        chk("rst_digits", load_digits, 0);
        chk("rst_enablen", cnt_enablen, 1);
        chk("rst_mag", magnetron_on, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b1;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("idle_start_load", load, 0);
        chk("idle_start_state", state_dbg, 0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd0); key(4'd5);
        chk("entry_state", state_dbg, 1);
        key(4'd12);
        chk("bad_key_state", state_dbg, 1);
        start = 1'b1;
        cyc();
        chk("start_load", load, 1);
        chk("start_digits", load_digits, 16'h2305);
        chk("start_state", state_dbg, 2);
        chk("start_mag", magnetron_on, 1);
        chk("start_enablen", cnt_enablen, 1);
        cyc();
        start = 1'b0;
        chk("held_start_noload", load, 0);
        chk("tick_1", cnt_enablen, 1);
        for (int k = 2; k <= 14; k++) begin
            cyc();
            chk($sformatf("tick_%0d", k), cnt_enablen, (k % 4 == 0) ? 16'd0 : 16'd1);
            chk($sformatf("tick_load_%0d", k), load, 0);
        end
        door_open = 1'b1;
        cyc();
        chk("door_state", state_dbg, 3);
        chk("door_mag", magnetron_on, 0);
        chk("door_enablen", cnt_enablen, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("door_start_state", state_dbg, 3);
        door_open = 1'b0;
        cyc();
        chk("closed_state", state_dbg, 3);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume_state", state_dbg, 2);
        chk("resume_mag", magnetron_on, 1);
        chk("resume_load", load, 0);
        cyc();
        chk("resume_tick1", cnt_enablen, 1);
        cyc();
        chk("resume_tick2", cnt_enablen, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("pre_zero_%0d", k), cnt_enablen, 1);
        end
        time_zero = 1'b1;
        cyc();
        chk("zero_enablen", cnt_enablen, 1);
        chk("zero_done", done, 1);
        chk("zero_mag", magnetron_on, 0);
        chk("zero_state", state_dbg, 4);
        cyc();
        chk("zero_hold_enablen", cnt_enablen, 1);
        chk("zero_hold_done", done, 1);
        time_zero = 1'b0;
        key(4'd7);
        chk("done_key_state", state_dbg, 0);
        chk("done_key_done", done, 0);
        key(4'd9);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("cleared_entry_digits", load_digits, 16'h0009);
        chk("cleared_entry_load", load, 1);
        stop_clear = 1'b1;
        cyc();
        chk("stop_cook_state", state_dbg, 3);
        cyc();
        stop_clear = 1'b0;
        chk("pause_clear_load", load, 1);
        chk("pause_clear_digits", load_digits, 16'h0000);
        chk("pause_clear_state", state_dbg, 0);
        cyc();
        chk("pause_clear_load_off", load, 0);
        key(4'd4);
        chk("key4_state", state_dbg, 1);
        start = 1'b1;
        stop_clear = 1'b1;
        cyc();
        start = 1'b0;
        stop_clear = 1'b0;
        chk("both_state", state_dbg, 0);
        chk("both_load", load, 0);
        key(4'd0);
        chk("zero_entry_state", state_dbg, 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("zero_entry_load", load, 0);
        chk("zero_entry_stay", state_dbg, 1);
        key(4'd8);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("cook8_digits", load_digits, 16'h0008);
        for (int k = 0; k < 4; k++) cyc();
        chk("pre_rst_enablen", cnt_enablen, 0);
        rst = 1'b0;
        #1;
        chk("async_enablen", cnt_enablen, 1);
        chk("async_mag", magnetron_on, 0);
        chk("async_state", state_dbg, 0);
        chk("async_digits", load_digits, 0);
        chk("async_load", load, 0);
        chk("async_done", done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
